// File: rtl/machine_ctrl.sv
// machine_ctrl: eight-phase instruction sequencer for the 8-bit RISC CPU.
// It runs on clk_ctrl from the clock generator. Each instruction steps through
// phases P0..P7. The datapath strobes are decoded from the 3-bit opcode and the
// accumulator zero flag.
//
// All strobes are registered. They are computed from the phase being entered,
// so the values for Pn are visible for the whole cycle in which phase == n.
// P0 strobes are issued only if ena is high on the edge that enters P0. If ena
// is low on that edge, the FSM stays in P0 with all strobes low until ena
// rises. Once a fetch has started, the instruction always completes.
//
// Optional build macro: MACHINE_CTRL_PERF_CNT_EN. When it is defined, the block
// gets the CNTW parameter and the instr_count port. instr_count is a saturating
// count of retired instructions.
//
// Handshake: this block has no valid/ready interfaces. The only inputs are the
// level enable ena, which is sampled on P0 entry, and the decoded opcode and
// zero flag, which are sampled on every phase edge.
module machine_ctrl #(
  parameter int OPW  = 3
`ifdef MACHINE_CTRL_PERF_CNT_EN
  ,
  parameter int CNTW = 16
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ena,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  output logic            inc_pc,
  output logic            load_pc,
  output logic            load_ir,
  output logic            load_acc,
  output logic            rd,
  output logic            wr,
  output logic            datactl_ena,
  output logic            halt,
  output logic [2:0]      phase
`ifdef MACHINE_CTRL_PERF_CNT_EN
  ,
  output logic [CNTW-1:0] instr_count
`endif
);

  localparam logic [OPW-1:0] OP_HLT = 3'b000;
  localparam logic [OPW-1:0] OP_SKZ = 3'b001;
  localparam logic [OPW-1:0] OP_ADD = 3'b010;
  localparam logic [OPW-1:0] OP_AND = 3'b011;
  localparam logic [OPW-1:0] OP_XOR = 3'b100;
  localparam logic [OPW-1:0] OP_LDA = 3'b101;
  localparam logic [OPW-1:0] OP_STO = 3'b110;
  localparam logic [OPW-1:0] OP_JMP = 3'b111;

  typedef enum logic [3:0] {
    P0, P1, P2, P3, P4, P5, P6, P7, HALTED
  } state_t;

  state_t state;
  state_t state_next;

  logic inc_pc_next;
  logic load_pc_next;
  logic load_ir_next;
  logic load_acc_next;
  logic rd_next;
  logic wr_next;
  logic datactl_ena_next;
  logic halt_next;
  logic alu_op;

  // ALU-class instructions all fetch their operand from memory.
  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

  // Next phase, plus the strobes for the phase being entered.
  always_comb begin
    state_next       = state;
    inc_pc_next      = 1'b0;
    load_pc_next     = 1'b0;
    load_ir_next     = 1'b0;
    load_acc_next    = 1'b0;
    rd_next          = 1'b0;
    wr_next          = 1'b0;
    datactl_ena_next = 1'b0;
    halt_next        = 1'b0;

    // P0 moves on only after it has issued its fetch strobes.
    // load_ir marks that the fetch has been issued.
    case (state)
      P0:      state_next = load_ir ? P1 : P0;
      P1:      state_next = P2;
      P2:      state_next = P3;
      P3:      state_next = (opcode == OP_HLT) ? HALTED : P4;
      P4:      state_next = P5;
      P5:      state_next = P6;
      P6:      state_next = P7;
      P7:      state_next = P0;
      HALTED:  state_next = HALTED;
      default: state_next = P0;
    endcase

    case (state_next)
      P0: begin
        rd_next      = ena;
        load_ir_next = ena;
      end
      P1: begin
        rd_next      = 1'b1;
        load_ir_next = 1'b1;
        inc_pc_next  = 1'b1;
      end
      P3: begin
        if (opcode == OP_HLT) halt_next = 1'b1;
        else                  inc_pc_next = 1'b1;
      end
      P4: begin
        rd_next          = alu_op;
        load_pc_next     = (opcode == OP_JMP);
        datactl_ena_next = (opcode == OP_STO);
      end
      P5: begin
        rd_next          = alu_op;
        load_acc_next    = alu_op;
        inc_pc_next      = (opcode == OP_SKZ) && zero;
        load_pc_next     = (opcode == OP_JMP);
        datactl_ena_next = (opcode == OP_STO);
        wr_next          = (opcode == OP_STO);
      end
      P6: begin
        rd_next          = alu_op;
        datactl_ena_next = (opcode == OP_STO);
      end
      P7: begin
        inc_pc_next = (opcode == OP_SKZ) && zero;
      end
      HALTED: begin
        halt_next = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Registers for the phase state, the strobes and the debug phase index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= P0;
      inc_pc      <= 1'b0;
      load_pc     <= 1'b0;
      load_ir     <= 1'b0;
      load_acc    <= 1'b0;
      rd          <= 1'b0;
      wr          <= 1'b0;
      datactl_ena <= 1'b0;
      halt        <= 1'b0;
      phase       <= 3'd0;
    end else begin
      state       <= state_next;
      inc_pc      <= inc_pc_next;
      load_pc     <= load_pc_next;
      load_ir     <= load_ir_next;
      load_acc    <= load_acc_next;
      rd          <= rd_next;
      wr          <= wr_next;
      datactl_ena <= datactl_ena_next;
      halt        <= halt_next;
      phase       <= (state_next == HALTED) ? 3'd3 : state_next[2:0];
    end
  end

`ifdef MACHINE_CTRL_PERF_CNT_EN
  logic retire;

  // An instruction retires at the end of P7, or at P3 when the opcode is HLT.
  assign retire = (state == P7) || ((state == P3) && (state_next == HALTED));

  // Saturating count of retired instructions.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count <= '0;
    end else if (retire && (instr_count != {CNTW{1'b1}})) begin
      instr_count <= instr_count + CNTW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_machine_ctrl.sv
// Directed bench for machine_ctrl. Strobes are packed as
// {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt} followed by the phase.
// Define MACHINE_CTRL_PERF_CNT_EN to build with the counter (CNTW=2) and to enable
// the counter checks.
module tb_machine_ctrl;

  logic       clk;
  logic       reset;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic       inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt;
  logic [2:0] phase;
`ifdef MACHINE_CTRL_PERF_CNT_EN
  logic [1:0] instr_count;
`endif

  int checks;
  int errors;

  // Hand-written per-phase strobe bytes for P0..P7, with P0 in the top byte.
  localparam logic [63:0] TAB_ALU  = 64'h28A8_0080_0818_0800;
  localparam logic [63:0] TAB_SKZ1 = 64'h28A8_0080_0080_0080;
  localparam logic [63:0] TAB_SKZ0 = 64'h28A8_0080_0000_0000;
  localparam logic [63:0] TAB_STO  = 64'h28A8_0080_0206_0200;
  localparam logic [63:0] TAB_JMP  = 64'h28A8_0080_4040_0000;

`ifdef MACHINE_CTRL_PERF_CNT_EN
  machine_ctrl #(.OPW(3), .CNTW(2)) dut (
`else
  machine_ctrl #(.OPW(3)) dut (
`endif
    .clk         (clk),
    .reset       (reset),
    .ena         (ena),
    .opcode      (opcode),
    .zero        (zero),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_ir     (load_ir),
    .load_acc    (load_acc),
    .rd          (rd),
    .wr          (wr),
    .datactl_ena (datactl_ena),
    .halt        (halt),
    .phase       (phase)
`ifdef MACHINE_CTRL_PERF_CNT_EN
    ,
    .instr_count (instr_count)
`endif
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [10:0] exp);
    logic [10:0] obs;
    obs = {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt, phase};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

`ifdef MACHINE_CTRL_PERF_CNT_EN
  task automatic chk_cnt(input string tag, input logic [1:0] exp);
    checks++;
    assert (instr_count === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, instr_count, exp);
    end
  endtask
`endif

  // Runs one instruction, starting in an active P0. It checks every phase and
  // ends in the next P0.
  task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                           input logic [63:0] tab);
    opcode = op;
    zero   = z;
    for (int p = 0; p < 8; p++) begin
      if (p > 0) step();
      chk($sformatf("%s_p%0d", tag, p), {tab[63-8*p -: 8], 3'(p)});
    end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    ena    = 1'b0;
    opcode = 3'b010;
    zero   = 1'b0;

    // Reset state, then idle in P0 while ena is low.
    step();
    chk("reset", 11'h000);
    reset = 1'b0;
    step();
    chk("idle_ena0", 11'h000);
    step();
    chk("idle_ena0_b", 11'h000);
    ena = 1'b1;
    step();
    chk("fetch_start", {8'h28, 3'd0});

    // Reset in the middle of P5 of an ADD.
    opcode = 3'b010;
    for (int p = 1; p < 6; p++) begin
      step();
      chk($sformatf("add_pre_p%0d", p), {TAB_ALU[63-8*p -: 8], 3'(p)});
    end
    reset = 1'b1;
    step();
    chk("reset_mid_p5", 11'h000);
    reset = 1'b0;
    step();
    chk("resume_fetch", {8'h28, 3'd0});

    // Each instruction class.
    run_instr("add",  3'b010, 1'b0, TAB_ALU);
    run_instr("skz1", 3'b001, 1'b1, TAB_SKZ1);
    run_instr("skz0", 3'b001, 1'b0, TAB_SKZ0);
    run_instr("sto",  3'b110, 1'b0, TAB_STO);
    run_instr("jmp",  3'b111, 1'b1, TAB_JMP);
    run_instr("xor",  3'b100, 1'b1, TAB_ALU);
    run_instr("lda",  3'b101, 1'b0, TAB_ALU);

    // Dropping ena mid-instruction lets it finish; the FSM then waits in P0.
    opcode = 3'b011;
    chk("and_p0", {8'h28, 3'd0});
    step();
    step();
    ena = 1'b0;
    for (int p = 3; p < 8; p++) begin
      step();
      chk($sformatf("and_noena_p%0d", p), {TAB_ALU[63-8*p -: 8], 3'(p)});
    end
    step();
    chk("wait_p0", 11'h000);
    step();
    chk("wait_p0_b", 11'h000);
    ena = 1'b1;
    step();
    chk("refetch", {8'h28, 3'd0});

`ifdef MACHINE_CTRL_PERF_CNT_EN
    // Saturating retire counter with a 2-bit width.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk_cnt("cnt_reset", 2'd0);
`endif
    for (int i = 1; i <= 5; i++) begin
      run_instr($sformatf("cnt_add%0d", i), 3'b010, 1'b0, TAB_ALU);
`ifdef MACHINE_CTRL_PERF_CNT_EN
      chk_cnt($sformatf("cnt_%0d", i), (i < 3) ? 2'(i) : 2'd3);
`endif
    end

    // HLT is sticky and ignores ena; only reset clears it.
    opcode = 3'b000;
    for (int p = 0; p < 3; p++) begin
      if (p > 0) step();
      chk($sformatf("hlt_p%0d", p), {TAB_ALU[63-8*p -: 8], 3'(p)});
    end
    step();
    chk("hlt_p3", {8'h01, 3'd3});
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("halted_%0d", i), {8'h01, 3'd3});
    end
    reset = 1'b1;
    step();
    chk("halt_cleared", 11'h000);
    reset = 1'b0;
    step();
    chk("post_halt_fetch", {8'h28, 3'd0});

    // Final report.
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/machine_ctrl.md
Name: machine_ctrl

Overview:
- Instruction-sequencing controller for the 8-bit RISC CPU. It sits directly downstream of the clock generator and is clocked by clk_ctrl.
- It steps an 8-phase state machine per instruction, aligned with the generator's cycle0..cycle7, and issues datapath strobes from the decoded 3-bit opcode and the accumulator zero flag.
- Strobes drive the PC, instruction register, accumulator, memory read/write and the data-bus driver.

Parameters:
- OPW, 3, opcode width (fixed ISA; no other value is supported)
- CNTW, 16, instruction counter width (optional feature only)

Ports:
- clk  input  1  controller clock; connected to clk_ctrl; all state changes on posedge
- reset  input  1  synchronous, active-high
- ena  input  1  run enable from the fetch-enable latch; 0 holds the FSM at P0
- opcode  input  3  IR[15:13]: HLT=000 SKZ=001 ADD=010 AND=011 XOR=100 LDA=101 STO=110 JMP=111
- zero  input  1  accumulator==0 flag
- inc_pc  output  1  PC increment strobe
- load_pc  output  1  PC parallel load from IR address field
- load_ir  output  1  IR byte load
- load_acc  output  1  accumulator load from ALU
- rd  output  1  memory read
- wr  output  1  memory write
- datactl_ena  output  1  drive ALU output onto the data bus
- halt  output  1  sticky halt indicator
- phase  output  3  current phase index, for debug
- instr_count  output  CNTW  retired instruction count (MACHINE_CTRL_PERF_CNT_EN only)

Behaviour:
- Reset (sync, dominant over ena): state=P0 and all outputs 0, including halt and phase; instr_count=0. Reset mid-instruction aborts the instruction; P0 is seen on the next edge.
- States: P0..P7 plus HALTED. Outputs are registered: the values listed for Pn are present during phase n, i.e. in the cycle after entering Pn.
- ena=0 while in P0: stay in P0 with all strobes 0. ena=0 in any other phase has no effect; the instruction completes and the FSM then waits in P0.
- P0: rd=1, load_ir=1 (high byte).
- P1: rd=1, load_ir=1, inc_pc=1.
- P2: all strobes 0.
- P3:
  - opcode HLT: halt=1 and next state is HALTED.
  - Otherwise inc_pc=1 (low byte consumed).
- P4:
  - ADD, AND, XOR, LDA: rd=1.
  - JMP: load_pc=1.
  - STO: datactl_ena=1.
  - SKZ: all 0.
- P5:
  - ADD, AND, XOR, LDA: rd=1, load_acc=1.
  - SKZ with zero=1: inc_pc=1.
  - JMP: load_pc=1, inc_pc=0.
  - STO: datactl_ena=1, wr=1.
- P6:
  - ADD, AND, XOR, LDA: rd=1.
  - STO: datactl_ena=1.
- P7:
  - SKZ with zero=1: inc_pc=1 (a skip costs 2 increments, i.e. one 16-bit word).
  - Otherwise 0.
  - Next state is P0.
- opcode and zero are sampled in each phase; the IR is stable from P2 onward.
- HALTED: all strobes 0, halt=1, phase=3. Only reset exits HALTED; ena is ignored.
- Never both rd=1 and wr=1; never load_pc=1 and inc_pc=1 together.

Optional Feature:
- MACHINE_CTRL_PERF_CNT_EN defined:
  - instr_count port exists.
  - Increments at P7→P0, and on P3→HALTED for HLT.
  - Saturates at 2^CNTW-1 with no wrap.
  - Cleared by reset.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset asserted mid-P5 of an ADD → next cycle phase=0 and all strobes 0; with ena=1 the fetch resumes with rd=1, load_ir=1.
- ena=1, opcode=010 (ADD) → inc_pc high in P1 and P3 only; rd high P0,P1,P4,P5,P6; load_acc high only in P5; 8 cycles per instruction.
- opcode=001 (SKZ): zero=1 → 4 inc_pc pulses (P1,P3,P5,P7); zero=0 → 2 pulses (P1,P3).
- opcode=110 (STO) → datactl_ena high P4–P6, wr high only in P5, rd never high after P1.
- opcode=000 (HLT) → halt=1 from P3 onward, strobes stay 0 for 20 cycles despite ena=1; reset clears halt.
- MACHINE_CTRL_PERF_CNT_EN with CNTW=2: run 5 instructions → instr_count = 1,2,3,3,3.
